// File: rtl/io_pkg.sv
// Shared constants for the memory-mapped I/O responder: register offsets,
// STATUS bit layout and default sizing.
package io_pkg;

  localparam logic [15:0] DEFAULT_BASE_ADDR  = 16'hFF00;
  localparam int unsigned DEFAULT_FIFO_DEPTH = 4;

  // Byte offsets inside the 16-byte window
  localparam logic [3:0] OFF_TXDATA = 4'h0;
  localparam logic [3:0] OFF_STATUS = 4'h2;
  localparam logic [3:0] OFF_IN     = 4'h4;
  localparam logic [3:0] OFF_CYCLE  = 4'h6;
  localparam logic [3:0] OFF_HALT   = 4'h8;

  // Word indices (address bit 0 is ignored)
  localparam logic [2:0] IDX_TXDATA = OFF_TXDATA[3:1];
  localparam logic [2:0] IDX_STATUS = OFF_STATUS[3:1];
  localparam logic [2:0] IDX_IN     = OFF_IN[3:1];
  localparam logic [2:0] IDX_CYCLE  = OFF_CYCLE[3:1];
  localparam logic [2:0] IDX_HALT   = OFF_HALT[3:1];

  // STATUS bit positions
  localparam int unsigned ST_FULL    = 0;
  localparam int unsigned ST_EMPTY   = 1;
  localparam int unsigned ST_OVF     = 2;
  localparam int unsigned ST_CNT_LSB = 3;

endpackage

// File: rtl/io_fifo.sv
// Output FIFO: power-of-two depth, wrapping pointers, occupancy counter.
// A push while full is accepted only when a pop happens in the same cycle.
module io_fifo
  import io_pkg::*;
#(
  parameter  int unsigned DEPTH = DEFAULT_FIFO_DEPTH,
  localparam int unsigned CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [15:0]   din,
  input  logic          pop,
  output logic [15:0]   dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [15:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign full      = (r_count == CW'(DEPTH));
  assign empty     = (r_count == '0);
  assign w_do_pop  = pop && !empty;
  assign w_do_push = push && (!full || w_do_pop);
  assign count     = r_count;
  assign dout      = empty ? '0 : r_mem[r_rd_ptr];

  // Storage array; contents are don't-care while empty because dout is gated
  always_ff @(posedge clk) begin
    if (w_do_push && !reset) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  // Pointer and occupancy tracking
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
    end
  end

endmodule

// File: rtl/io_responder.sv
// Memory-mapped I/O responder: address decode, registered read data,
// overflow/halt flags, cycle counter and input sampling around io_fifo.
module io_responder
  import io_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR  = DEFAULT_BASE_ADDR,
  parameter int unsigned FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] addr,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [15:0] wdata,
  output logic [15:0] rdata,
  output logic        hit,
  input  logic [15:0] in_port,
  output logic [15:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        halt
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  logic [15:0]   r_rdata;
  logic [15:0]   r_in;
  logic [15:0]   r_cycle;
  logic          r_ovf;
  logic          r_halt;

  logic          w_hit;
  logic [2:0]    w_idx;
  logic          w_wr;
  logic          w_rd;
  logic          w_push;
  logic          w_pop;
  logic          w_full;
  logic          w_empty;
  logic [CW-1:0] w_count;
  logic [15:0]   w_count16;
  logic [15:0]   w_status;
  logic [15:0]   w_rsel;
  logic          w_unused_addr0;

  assign w_hit          = (addr[15:4] == BASE_ADDR[15:4]);
  assign w_idx          = addr[3:1];
  assign w_wr           = mem_write && w_hit;
  assign w_rd           = mem_read && !mem_write && w_hit;
  assign w_push         = w_wr && (w_idx == IDX_TXDATA);
  assign w_pop          = out_valid && out_ready;
  assign w_count16      = 16'(w_count);
  assign w_unused_addr0 = addr[0];

  assign hit       = w_hit;
  assign rdata     = r_rdata;
  assign halt      = r_halt;
  assign out_valid = !w_empty;

  io_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .reset(reset),
    .push (w_push),
    .din  (wdata),
    .pop  (w_pop),
    .dout (out_data),
    .full (w_full),
    .empty(w_empty),
    .count(w_count)
  );

  // STATUS word assembly
  always_comb begin
    w_status                    = '0;
    w_status[ST_CNT_LSB +: 3]   = w_count16[2:0];
    w_status[ST_OVF]            = r_ovf;
    w_status[ST_EMPTY]          = w_empty;
    w_status[ST_FULL]           = w_full;
  end

  // Read-data selection by word index
  always_comb begin
    w_rsel = '0;
    case (w_idx)
      IDX_TXDATA: w_rsel = w_count16;
      IDX_STATUS: w_rsel = w_status;
      IDX_IN:     w_rsel = r_in;
      IDX_CYCLE:  w_rsel = r_cycle;
      IDX_HALT:   w_rsel = {15'b0, r_halt};
      default:    w_rsel = '0;
    endcase
  end

  // Registered response, flags, cycle counter and input sample
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rdata <= '0;
      r_in    <= '0;
      r_cycle <= '0;
      r_ovf   <= 1'b0;
      r_halt  <= 1'b0;
    end else begin
      r_rdata <= w_rd ? w_rsel : '0;
      r_in    <= in_port;
      if (!r_halt) r_cycle <= r_cycle + 16'd1;
      if (w_push && w_full && !w_pop) begin
        r_ovf <= 1'b1;
      end else if (w_wr && (w_idx == IDX_STATUS) && wdata[ST_OVF]) begin
        r_ovf <= 1'b0;
      end
      if (w_wr && (w_idx == IDX_HALT) && wdata[0]) r_halt <= 1'b1;
    end
  end

endmodule

// File: tb/tb_io_responder.sv
// Self-checking bench for io_responder: constant vector table, directed
// corner-case sequences and randomized traffic against a queue-based model.
module tb_io_responder;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] addr = 16'h0;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [15:0] wdata = 16'h0;
  logic [15:0] rdata;
  logic        hit;
  logic [15:0] in_port = 16'h0;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        halt;

  always #5 clk = ~clk;

  io_responder #(
    .BASE_ADDR (16'hFF00),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .addr     (addr),
    .mem_read (mem_read),
    .mem_write(mem_write),
    .wdata    (wdata),
    .rdata    (rdata),
    .hit      (hit),
    .in_port  (in_port),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .halt     (halt)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Behavioural reference: queue of words plus flags
  logic [15:0] mq[$];
  logic        m_ov = 1'b0;
  logic        m_halt = 1'b0;
  logic [15:0] m_cyc = 16'h0;
  logic [15:0] m_in = 16'h0;
  logic [15:0] m_rdata = 16'h0;

  function automatic logic m_hit(input logic [15:0] a);
    return a[15:4] == 12'hFF0;
  endfunction

  function automatic logic [15:0] m_value(input logic [15:0] a);
    logic [15:0] s;
    s = '0;
    case (a[3:1])
      3'd0: return 16'(mq.size());
      3'd1: begin
        s[5:3] = 3'(mq.size());
        s[2]   = m_ov;
        s[1]   = (mq.size() == 0);
        s[0]   = (mq.size() == DEPTH);
        return s;
      end
      3'd2: return m_in;
      3'd3: return m_cyc;
      3'd4: return {15'b0, m_halt};
      default: return 16'h0;
    endcase
  endfunction

  task automatic model_step();
    logic wr, rd, pop, was_full;
    if (reset) begin
      mq.delete();
      m_ov = 0; m_halt = 0; m_cyc = 0; m_in = 0; m_rdata = 0;
      return;
    end
    wr       = mem_write && m_hit(addr);
    rd       = mem_read && !mem_write && m_hit(addr);
    m_rdata  = rd ? m_value(addr) : 16'h0;
    pop      = (mq.size() != 0) && out_ready;
    was_full = (mq.size() == DEPTH);
    if (pop) void'(mq.pop_front());
    if (wr && addr[3:1] == 3'd0) begin
      if (was_full && !pop) m_ov = 1;
      else mq.push_back(wdata);
    end
    if (wr && addr[3:1] == 3'd1 && wdata[2]) m_ov = 0;
    if (!m_halt) m_cyc = m_cyc + 16'd1;
    if (wr && addr[3:1] == 3'd4 && wdata[0]) m_halt = 1;
    m_in = in_port;
  endtask

  // One clock: check comb hit, advance model, sample #1 after the edge
  task automatic tick();
    logic [15:0] head;
    #1;
    check("hit", 64'(hit), 64'(m_hit(addr)));
    model_step();
    @(posedge clk);
    #1;
    head = (mq.size() != 0) ? mq[0] : 16'h0;
    check("model_outputs", 64'({rdata, out_valid, out_data, halt}),
          64'({m_rdata, (mq.size() != 0), head, m_halt}));
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    addr = a; wdata = d; mem_write = 1'b1;
    tick();
    mem_write = 1'b0;
  endtask

  task automatic rd(input logic [15:0] a, output logic [15:0] v);
    addr = a; mem_read = 1'b1;
    tick();
    v = rdata;
    mem_read = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  typedef struct {
    logic [15:0] a;
    logic        r;
    logic        w;
    logic [15:0] d;
    logic        exp_hit;
    logic [15:0] exp_rdata;
  } vec_t;

  vec_t vt[17];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] v, c1, c2;
    logic [15:0] exp_drain[4];
    int n;

    vt[0]  = '{16'hFF00, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0000};
    vt[1]  = '{16'hFF02, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0002};
    vt[2]  = '{16'hFF04, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h5A5A};
    vt[3]  = '{16'hFF08, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0000};
    vt[4]  = '{16'hFF0A, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0000};
    vt[5]  = '{16'hFF0E, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0000};
    vt[6]  = '{16'hFEFE, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000};
    vt[7]  = '{16'hFF10, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000};
    vt[8]  = '{16'hFF00, 1'b0, 1'b1, 16'h1111, 1'b1, 16'h0000};
    vt[9]  = '{16'hFF00, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0001};
    vt[10] = '{16'hFF02, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0008};
    vt[11] = '{16'hFF00, 1'b1, 1'b1, 16'h2222, 1'b1, 16'h0000};
    vt[12] = '{16'hFF00, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0002};
    vt[13] = '{16'hFF0A, 1'b0, 1'b1, 16'hFFFF, 1'b1, 16'h0000};
    vt[14] = '{16'hFF02, 1'b0, 1'b1, 16'h0004, 1'b1, 16'h0000};
    vt[15] = '{16'hFF02, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0010};
    vt[16] = '{16'hFF03, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0010};

    // Reset state
    in_port = 16'h5A5A;
    do_reset();
    check("reset_out_valid", 64'(out_valid), 64'(0));
    check("reset_out_data", 64'(out_data), 64'(0));
    check("reset_halt", 64'(halt), 64'(0));
    check("reset_rdata", 64'(rdata), 64'(0));
    tick();

    // Vector table
    for (int i = 0; i < 17; i++) begin
      addr = vt[i].a; mem_read = vt[i].r; mem_write = vt[i].w; wdata = vt[i].d;
      #1;
      check($sformatf("vec%0d_hit", i), 64'(hit), 64'(vt[i].exp_hit));
      tick();
      check($sformatf("vec%0d_rdata", i), 64'(rdata), 64'(vt[i].exp_rdata));
      mem_read = 1'b0; mem_write = 1'b0;
    end

    // First push, no bypass
    do_reset();
    addr = 16'hFF00; wdata = 16'h1234; mem_write = 1'b1;
    #1;
    check("no_bypass", 64'(out_valid), 64'(0));
    tick();
    mem_write = 1'b0;
    check("push_valid", 64'(out_valid), 64'(1));
    check("push_data", 64'(out_data), 64'(16'h1234));
    rd(16'hFF02, v);
    check("status_one", 64'(v), 64'(16'h0008));

    // Overflow and clear
    do_reset();
    for (int k = 0; k < 5; k++) wr(16'hFF00, 16'hA000 + 16'(k));
    rd(16'hFF02, v);
    check("status_ovf", 64'(v), 64'(16'h0025));
    check("head_first", 64'(out_data), 64'(16'hA000));
    wr(16'hFF02, 16'h0004);
    rd(16'hFF02, v);
    check("status_clr", 64'(v), 64'(16'h0021));

    // Push and pop together while full
    out_ready = 1'b1;
    addr = 16'hFF00; wdata = 16'hBEEF; mem_write = 1'b1;
    tick();
    mem_write = 1'b0; out_ready = 1'b0;
    rd(16'hFF02, v);
    check("full_pushpop", 64'(v), 64'(16'h0021));
    exp_drain = '{16'hA001, 16'hA002, 16'hA003, 16'hBEEF};
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("drain%0d", i), 64'(out_data), 64'(exp_drain[i]));
      tick();
    end
    check("drained", 64'(out_valid), 64'(0));
    out_ready = 1'b0;

    // IN sampling and unmapped read
    in_port = 16'hA5A5;
    tick();
    tick();
    in_port = 16'h0000;
    rd(16'hFF04, v);
    check("in_read", 64'(v), 64'(16'hA5A5));
    rd(16'hFF0C, v);
    check("unmapped", 64'(v), 64'(0));
    tick();
    check("rdata_idle", 64'(rdata), 64'(0));

    // Halt freezes CYCLE, FIFO still drains
    for (int k = 0; k < 3; k++) wr(16'hFF00, 16'hC000 + 16'(k));
    rd(16'hFF06, c1);
    wr(16'hFF08, 16'h0001);
    check("halt_set", 64'(halt), 64'(1));
    repeat (10) tick();
    rd(16'hFF06, c2);
    check("cycle_frozen", 64'(c2), 64'(c1 + 16'd2));
    rd(16'hFF08, v);
    check("halt_read", 64'(v), 64'(1));
    out_ready = 1'b1;
    n = 0;
    while (out_valid && n < 8) begin
      tick();
      n++;
    end
    check("halt_drain", 64'(out_valid), 64'(0));
    out_ready = 1'b0;

    // Reset with queued entries and halt set, concurrent traffic ignored
    for (int k = 0; k < 3; k++) wr(16'hFF00, 16'hD000 + 16'(k));
    check("queued_halt", 64'(halt), 64'(1));
    reset = 1'b1; addr = 16'hFF00; wdata = 16'h7777;
    mem_write = 1'b1; mem_read = 1'b1; out_ready = 1'b1;
    tick();
    reset = 1'b0; mem_write = 1'b0; mem_read = 1'b0; out_ready = 1'b0;
    check("rst_valid", 64'(out_valid), 64'(0));
    check("rst_halt", 64'(halt), 64'(0));
    check("rst_rdata", 64'(rdata), 64'(0));
    rd(16'hFF06, v);
    check("rst_cycle", 64'(v), 64'(0));
    rd(16'hFF02, v);
    check("rst_status", 64'(v), 64'(16'h0002));

    // Randomized traffic against the model
    for (int pass = 0; pass < 2; pass++) begin
      do_reset();
      for (int i = 0; i < 300; i++) begin
        in_port   = 16'($urandom);
        out_ready = ($urandom_range(0, 3) == 0);
        if ($urandom_range(0, 9) < 8) begin
          if ($urandom_range(0, 1) == 0) addr = {12'hFF0, 3'd0, 1'($urandom)};
          else addr = {12'hFF0, 3'($urandom_range(0, 7)), 1'($urandom)};
        end else begin
          addr = 16'($urandom);
        end
        mem_read  = ($urandom_range(0, 2) == 0);
        mem_write = ($urandom_range(0, 2) == 0);
        wdata     = 16'($urandom);
        if (addr[3:1] == 3'd4) wdata[0] = ($urandom_range(0, 20) == 0);
        reset     = ($urandom_range(0, 99) == 0);
        tick();
      end
      reset = 1'b0; mem_read = 1'b0; mem_write = 1'b0; out_ready = 1'b0;
    end
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
